// File: rtl/timer_mc_pkg.sv
// timer_mc_pkg: register offsets, CTRL bit positions and CTRL layout shared by the timer files
package timer_mc_pkg;
    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_LOAD  = 4'h4;
    localparam logic [3:0] OFF_COUNT = 4'h8;
    localparam logic [3:0] OFF_PRESC = 4'hC;
    localparam logic [7:0] ADDR_IRQ_STATUS = 8'hF0;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one prescaled down-counter with one-shot/periodic reload and an expiry strobe
module timer_channel import timer_mc_pkg::*; #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ctrl_we,
    input  logic               load_we,
    input  logic               presc_we,
    input  logic [DATA_W-1:0]  wdata,
    output ctrl_t              ctrl,
    output logic [CNT_W-1:0]   load,
    output logic [PRESC_W-1:0] presc,
    output logic [CNT_W-1:0]   count,
    output logic               expire
);
    logic [PRESC_W-1:0] pcnt;
    logic start, tick;

    assign start  = ctrl_we && wdata[CTRL_EN] && !ctrl.en;
    // >= keeps the tick alive if PRESCALE is lowered below the running prescaler count
    assign tick   = ctrl.en && (pcnt >= presc);
    assign expire = tick && (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl  <= '0;
            load  <= '0;
            presc <= '0;
            pcnt  <= '0;
            count <= '0;
        end else begin
            if (ctrl_we) ctrl <= ctrl_t'(wdata[2:0]);
            else if (expire && !ctrl.periodic) ctrl.en <= 1'b0;
            if (load_we) load <= wdata[CNT_W-1:0];
            if (presc_we) presc <= wdata[PRESC_W-1:0];
            if (start) pcnt <= '0;
            else if (ctrl.en) pcnt <= tick ? '0 : pcnt + 1'b1;
            if (start) count <= load;
            else if (tick) count <= (count != '0) ? count - 1'b1 : (ctrl.periodic ? load : count);
        end
    end
endmodule

// File: rtl/timer_periph_mc.sv
// timer_periph_mc: NUM_CH timer channels behind a req/gnt register bus with a shared W1C status and irq
module timer_periph_mc import timer_mc_pkg::*; #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req,
    output logic                    gnt,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    write_en,
    output logic [DATA_W-1:0]       rdata,
    output logic                    irq,
    output logic [NUM_CH-1:0]       debug_expired,
    output logic [NUM_CH*CNT_W-1:0] debug_counter
);
    ctrl_t              ctrl_a  [NUM_CH];
    logic [CNT_W-1:0]   load_a  [NUM_CH];
    logic [CNT_W-1:0]   count_a [NUM_CH];
    logic [PRESC_W-1:0] presc_a [NUM_CH];
    logic [NUM_CH-1:0]  expire, irq_en, status, clr;
    logic [DATA_W-1:0]  rd;
    logic [3:0]         ch_sel, off;
    logic               access, hi_ok, wr, st_sel;

    assign access = req && !gnt;
    assign ch_sel = addr[7:4];
    assign off    = addr[3:0];
    assign hi_ok  = (addr >> 8) == '0;
    assign wr     = access && write_en && hi_ok;
    assign st_sel = hi_ok && (addr[7:0] == ADDR_IRQ_STATUS);
    assign clr    = (wr && st_sel) ? wdata[NUM_CH-1:0] : '0;
    assign irq    = |(status & irq_en);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr && (ch_sel == 4'(i));
        timer_channel #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .DATA_W(DATA_W)) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .ctrl_we  (sel && off == OFF_CTRL),
            .load_we  (sel && off == OFF_LOAD),
            .presc_we (sel && off == OFF_PRESC),
            .wdata    (wdata),
            .ctrl     (ctrl_a[i]),
            .load     (load_a[i]),
            .presc    (presc_a[i]),
            .count    (count_a[i]),
            .expire   (expire[i])
        );
        assign irq_en[i] = ctrl_a[i].irq_en;
        assign debug_counter[i*CNT_W +: CNT_W] = count_a[i];
    end

    always_comb begin
        rd = st_sel ? DATA_W'(status) : '0;
        for (int i = 0; i < NUM_CH; i++)
            if (hi_ok && ch_sel == 4'(i))
                rd = off == OFF_CTRL  ? DATA_W'(ctrl_a[i])  :
                     off == OFF_LOAD  ? DATA_W'(load_a[i])  :
                     off == OFF_COUNT ? DATA_W'(count_a[i]) :
                     off == OFF_PRESC ? DATA_W'(presc_a[i]) : '0;
    end

    // a fresh expiry is OR-ed in after the clear so a same-edge set always wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt           <= 1'b0;
            rdata         <= '0;
            status        <= '0;
            debug_expired <= '0;
        end else begin
            gnt           <= access;
            rdata         <= (access && !write_en) ? rd : '0;
            status        <= (status & ~clr) | expire;
            debug_expired <= expire;
        end
    end
endmodule

// File: tb/tb_timer_periph_mc.sv
// tb_timer_periph_mc: table-driven register checks plus cycle-exact timer sequences
module tb_timer_periph_mc;
    logic         clk = 0, reset_n = 0, req = 0, write_en = 0;
    logic [7:0]   addr = 0;
    logic [31:0]  wdata = 0;
    logic         gnt, irq;
    logic [31:0]  rdata;
    logic [3:0]   debug_expired;
    logic [127:0] debug_counter;
    int checks = 0, failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic        w;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    timer_periph_mc dut (
        .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .addr(addr), .wdata(wdata),
        .write_en(write_en), .rdata(rdata), .irq(irq),
        .debug_expired(debug_expired), .debug_counter(debug_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // called on a negedge; access executes on the next posedge, returns one negedge after gnt
    task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic w, output logic [31:0] r);
        int n;
        n = 0;
        req = 1; addr = a; wdata = d; write_en = w;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt && n < 8);
        chk("gnt_latency", 32'(n), 32'd1);
        r = rdata;
        req = 0;
        @(negedge clk);
        chk("gnt_pulse", {31'b0, gnt}, 32'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] t;
        bus(a, d, 1'b1, t);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] t;
        bus(a, 32'h0, 1'b0, t);
        chk(name, t, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] t;
        vecs[0]  = '{8'h08, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{8'hF0, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{8'h34, 32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[3]  = '{8'h34, 32'h0,        1'b0, 32'hFFFFFFFF};
        vecs[4]  = '{8'h3C, 32'h00001234, 1'b1, 32'h0};
        vecs[5]  = '{8'h3C, 32'h0,        1'b0, 32'h34};
        vecs[6]  = '{8'h30, 32'hFFFFFFF6, 1'b1, 32'h0};
        vecs[7]  = '{8'h30, 32'h0,        1'b0, 32'h6};
        vecs[8]  = '{8'h38, 32'h55,       1'b1, 32'h0};
        vecs[9]  = '{8'h38, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{8'h31, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{8'h44, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{8'h30, 32'h0,        1'b1, 32'h0};
        vecs[13] = '{8'h30, 32'h0,        1'b0, 32'h0};

        #1;
        chk("rst_gnt", {31'b0, gnt}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_dbg_exp", {28'b0, debug_expired}, 32'd0);
        chk("rst_dbg_cnt", {31'b0, |debug_counter}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            bus(vecs[i].a, vecs[i].d, vecs[i].w, t);
            if (!vecs[i].w) chk($sformatf("vec%0d_rd_%h", i, vecs[i].a), t, vecs[i].exp);
        end

        wr(8'h04, 32'd3);
        wr(8'h0C, 32'd0);
        wr(8'h00, 32'h3);
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("ch0_cnt_k%0d", k), debug_counter[31:0], 32'(3 - (k % 4)));
            chk($sformatf("ch0_exp_k%0d", k), {31'b0, debug_expired[0]}, 32'(k % 4 == 0));
        end
        rd_chk("ch0_count_rd", 8'h08, 32'd2);

        wr(8'h14, 32'd2);
        wr(8'h1C, 32'd4);
        wr(8'h10, 32'h5);
        for (int k = 2; k <= 18; k++) begin
            @(negedge clk);
            chk($sformatf("ch1_exp_k%0d", k), {31'b0, debug_expired[1]}, 32'(k == 15));
            chk($sformatf("ch1_irq_k%0d", k), {31'b0, irq}, 32'(k >= 15));
        end
        rd_chk("ch1_ctrl_after", 8'h10, 32'h4);
        rd_chk("ch1_count_after", 8'h18, 32'h0);
        wr(8'hF0, 32'h2);
        chk("ch1_irq_cleared", {31'b0, irq}, 32'd0);

        wr(8'h00, 32'h0);
        wr(8'hF0, 32'h1);
        wr(8'h00, 32'h3);
        @(negedge clk);
        @(negedge clk);
        wr(8'hF0, 32'h1);
        rd_chk("w1c_set_wins", 8'hF0, 32'h1);
        @(negedge clk);
        wr(8'hF0, 32'h1);
        rd_chk("w1c_clear", 8'hF0, 32'h0);

        wr(8'h24, 32'd5);
        wr(8'h2C, 32'd0);
        wr(8'h20, 32'h3);
        wr(8'h24, 32'd1);
        for (int k = 4; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("ch2_cnt_k%0d", k), debug_counter[95:64], 32'(k <= 5 ? 5 - k : (k % 2 == 0 ? 1 : 0)));
            chk($sformatf("ch2_exp_k%0d", k), {31'b0, debug_expired[2]},
                32'(k == 6 || k == 8 || k == 10 || k == 12));
        end

        wr(8'h20, 32'h7);
        repeat (4) @(negedge clk);
        chk("ch2_irq", {31'b0, irq}, 32'd1);
        wr(8'hE4, 32'hDEADBEEF);
        rd_chk("unmapped_rd", 8'hE4, 32'h0);

        #2 reset_n = 0;
        #1;
        chk("midrst_cnt", {31'b0, |debug_counter}, 32'd0);
        chk("midrst_irq", {31'b0, irq}, 32'd0);
        chk("midrst_exp", {28'b0, debug_expired}, 32'd0);
        req = 1; addr = 8'h28; write_en = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_gnt", {31'b0, gnt}, 32'd0);
        reset_n = 1;
        @(negedge clk);
        chk("regrant_gnt", {31'b0, gnt}, 32'd1);
        chk("regrant_rdata", rdata, 32'd0);
        req = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
